stream_regressor: RTL and testbench

Parametrised streaming regressor for the NN datapath. It collects N samples of `x_in` into a window buffer and computes a dot product against a fixed coefficient set using LANES parallel multipliers, then adds a bias and saturates to produce `f_out`. It replaces the fixed 36-tap, non-overlapping regressor top. It adds a selectable sliding-window mode, configurable lane count, and a defined saturation rule.

---
 rtl/regressor_pkg.sv | 26 ++
 rtl/regressor_mac_lanes.sv | 35 +++
 rtl/stream_regressor.sv | 156 +++++++++++++++
 tb/tb_stream_regressor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/regressor_pkg.sv
// Shared coefficient table, FSM state type and width helpers for stream_regressor.
package regressor_pkg;

  localparam int N_MAX = 64;

  // Coefficients are held as int and narrowed to WW at the point of use.
  localparam int W [0:N_MAX-1] = '{default: 1};

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_width(input int xw, input int ww, input int n);
    return xw + ww + 1 + clog2(n);
  endfunction

endpackage

// File: rtl/regressor_mac_lanes.sv
// Combinational multiply-add across LANES unsigned-sample / signed-coefficient pairs.
module regressor_mac_lanes #(
  parameter int XW    = 12,
  parameter int WW    = 12,
  parameter int LANES = 4,
  parameter int AW    = 31
) (
  input  logic [LANES*XW-1:0] i_x,
  input  logic [LANES*WW-1:0] i_w,
  output logic [AW-1:0]       o_sum
);

  localparam int PW = XW + WW + 1;

  logic signed [XW:0]    w_xe;
  logic signed [WW-1:0]  w_we;
  logic signed [PW-1:0]  w_prod;
  logic signed [AW-1:0]  w_acc;

  always_comb begin
    w_acc  = '0;
    w_xe   = '0;
    w_we   = '0;
    w_prod = '0;
    for (int j = 0; j < LANES; j++) begin
      w_xe   = $signed({1'b0, i_x[j*XW +: XW]});
      w_we   = $signed(i_w[j*WW +: WW]);
      w_prod = PW'(w_xe) * PW'(w_we);
      w_acc  = w_acc + AW'(w_prod);
    end
  end

  assign o_sum = w_acc;

endmodule

// File: rtl/stream_regressor.sv
// Windowed dot-product regressor with batch / sliding modes and output saturation.
// Build macro STREAM_REGRESSOR_RELU_EN clamps negative results to zero.
module stream_regressor
  import regressor_pkg::*;
#(
  parameter int XW    = 12,
  parameter int WW    = 12,
  parameter int OW    = 24,
  parameter int N     = 36,
  parameter int LANES = 4,
  parameter logic signed [OW-1:0] BIAS = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] x_in,
  input  logic          start,
  input  logic          mode,
  output logic [OW-1:0] f_out,
  output logic          ack,
  output logic          ready,
  output logic          busy
);

  localparam int BEATS = (N + LANES - 1) / LANES;
  localparam int PAD   = BEATS * LANES;
  localparam int AW    = acc_width(XW, WW, N);
  localparam int SW    = AW + 1;
  localparam int CW    = clog2(N + 1);
  localparam int BW    = (BEATS > 1) ? clog2(BEATS) : 1;

  state_e               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic                 r_mode_q;
  logic [BW-1:0]        r_beat;
  logic signed [AW-1:0] r_acc;
  logic [XW-1:0]        r_buf [N];
  logic [OW-1:0]        r_f_out;
  logic                 r_ack, r_ready;

  logic [XW-1:0]        w_xpad [PAD];
  logic [WW-1:0]        w_wpad [PAD];
  logic [LANES*XW-1:0]  w_lane_x;
  logic [LANES*WW-1:0]  w_lane_w;
  logic [AW-1:0]        w_beat_sum;
  logic                 w_accept, w_last_beat, w_window_full;
  logic signed [SW-1:0] w_total;
  logic [OW-1:0]        w_sat, w_result;

  // Zero-padded view so the final partial beat sees zeros beyond index N-1.
  for (genvar gi = 0; gi < PAD; gi++) begin : g_pad
    if (gi < N) begin : g_live
      assign w_xpad[gi] = r_buf[gi];
      assign w_wpad[gi] = WW'(W[gi]);
    end else begin : g_zero
      assign w_xpad[gi] = '0;
      assign w_wpad[gi] = '0;
    end
  end

  always_comb begin
    w_lane_x = '0;
    w_lane_w = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (r_beat == BW'(b)) begin
        for (int j = 0; j < LANES; j++) begin
          w_lane_x[j*XW +: XW] = w_xpad[b*LANES + j];
          w_lane_w[j*WW +: WW] = w_wpad[b*LANES + j];
        end
      end
    end
  end

  regressor_mac_lanes #(.XW(XW), .WW(WW), .LANES(LANES), .AW(AW)) u_mac (
    .i_x   (w_lane_x),
    .i_w   (w_lane_w),
    .o_sum (w_beat_sum)
  );

  assign w_accept      = start && (r_state == FILL);
  assign w_window_full = (r_cnt >= CW'(N - 1));
  assign w_last_beat   = (r_beat == BW'(BEATS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FILL;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:    if (w_accept && w_window_full) w_next = COMPUTE;
      COMPUTE: if (w_last_beat) w_next = DONE;
      DONE:    w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_mode_q <= 1'b0;
      r_beat   <= '0;
      r_acc    <= '0;
      r_f_out  <= '0;
      r_ack    <= 1'b0;
      r_ready  <= 1'b0;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else begin
      r_ack   <= w_accept;
      r_ready <= 1'b0;
      if (w_accept) begin
        r_buf[0] <= x_in;
        for (int i = 1; i < N; i++) r_buf[i] <= r_buf[i-1];
        if (r_cnt != CW'(N)) r_cnt <= r_cnt + CW'(1);
        if (r_cnt == '0 || r_cnt == CW'(N)) r_mode_q <= mode;
        if (w_window_full) begin
          r_acc  <= '0;
          r_beat <= '0;
        end
      end
      if (r_state == COMPUTE) begin
        r_acc  <= r_acc + $signed(w_beat_sum);
        r_beat <= r_beat + BW'(1);
      end
      if (r_state == DONE) begin
        r_f_out <= w_result;
        r_ready <= 1'b1;
        // Sliding mode keeps the full window so the next accept recomputes.
        if (!r_mode_q) r_cnt <= '0;
      end
    end
  end

  assign w_total = SW'(r_acc) + SW'(BIAS);

  always_comb begin
    if (w_total[SW-1:OW-1] == '0 || w_total[SW-1:OW-1] == '1)
      w_sat = w_total[OW-1:0];
    else if (w_total[SW-1])
      w_sat = {1'b1, {(OW-1){1'b0}}};
    else
      w_sat = {1'b0, {(OW-1){1'b1}}};
  end

`ifdef STREAM_REGRESSOR_RELU_EN
  assign w_result = w_sat[OW-1] ? '0 : w_sat;
`else
  assign w_result = w_sat;
`endif

  assign f_out = r_f_out;
  assign ack   = r_ack;
  assign ready = r_ready;
  assign busy  = (r_state != FILL);

endmodule

// File: tb/tb_stream_regressor.sv
// Self-checking bench for stream_regressor: default build plus saturation, bias and lane-count variants.
module tb_stream_regressor;
  import regressor_pkg::*;

`ifdef STREAM_REGRESSOR_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  localparam int NI = 6;
  localparam int LANES_V [NI] = '{4, 4, 4, 1, 5, 36};

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] x_in;
  logic        start, mode;
  logic [23:0] f_v     [NI];
  logic        ack_v   [NI];
  logic        ready_v [NI];
  logic        busy_v  [NI];

  int vec_cnt = 0;
  int miss_cnt = 0;
  int q_exp[$];
  int lat[NI], rdy_n[NI], fval[NI];
  int busy_n, acks, exp_v;

  always #5 clk = ~clk;

  stream_regressor u_dut (.clk(clk), .reset(reset), .x_in(x_in), .start(start), .mode(mode),
    .f_out(f_v[0]), .ack(ack_v[0]), .ready(ready_v[0]), .busy(busy_v[0]));
  stream_regressor #(.BIAS(24'sd8388000)) u_sat (.clk(clk), .reset(reset), .x_in(x_in), .start(start),
    .mode(mode), .f_out(f_v[1]), .ack(ack_v[1]), .ready(ready_v[1]), .busy(busy_v[1]));
  stream_regressor #(.BIAS(-24'sd5000)) u_neg (.clk(clk), .reset(reset), .x_in(x_in), .start(start),
    .mode(mode), .f_out(f_v[2]), .ack(ack_v[2]), .ready(ready_v[2]), .busy(busy_v[2]));
  stream_regressor #(.LANES(1)) u_l1 (.clk(clk), .reset(reset), .x_in(x_in), .start(start), .mode(mode),
    .f_out(f_v[3]), .ack(ack_v[3]), .ready(ready_v[3]), .busy(busy_v[3]));
  stream_regressor #(.LANES(5)) u_l5 (.clk(clk), .reset(reset), .x_in(x_in), .start(start), .mode(mode),
    .f_out(f_v[4]), .ack(ack_v[4]), .ready(ready_v[4]), .busy(busy_v[4]));
  stream_regressor #(.LANES(36)) u_l36 (.clk(clk), .reset(reset), .x_in(x_in), .start(start), .mode(mode),
    .f_out(f_v[5]), .ack(ack_v[5]), .ready(ready_v[5]), .busy(busy_v[5]));

  // Reference: window of 36 consecutive samples ending at 'newest' (index 0 = newest).
  function automatic int model(input int newest, input int bias_v);
    longint acc = 0;
    for (int i = 0; i < 36; i++) acc += longint'(W[i]) * longint'(newest - i);
    acc += longint'(bias_v);
    if (acc > 64'sd8388607) acc = 64'sd8388607;
    else if (acc < -64'sd8388608) acc = -64'sd8388608;
    if (RELU && acc < 0) acc = 0;
    return int'(acc);
  endfunction

  function automatic int exp_latency(input int lanes);
    return (36 + lanes - 1) / lanes + 1;
  endfunction

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; mode = 1'b0; x_in = '0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
  endtask

  // Drives n consecutive samples at negedges; returns at the negedge after the last accept.
  task automatic feed(input int base, input int n, input logic md);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ack_v[0]) acks++;
      x_in = 12'(base + i); start = 1'b1; mode = md;
    end
    @(negedge clk);
    if (ack_v[0]) acks++;
    start = 1'b0;
  endtask

  task automatic wait_results(input int budget);
    for (int k = 0; k < NI; k++) begin lat[k] = -1; rdy_n[k] = 0; fval[k] = 0; end
    busy_n = busy_v[0] ? 1 : 0;
    for (int m = 1; m <= budget; m++) begin
      @(negedge clk);
      if (busy_v[0]) busy_n++;
      for (int k = 0; k < NI; k++) begin
        if (ready_v[k]) begin
          rdy_n[k]++;
          if (lat[k] < 0) begin lat[k] = m; fval[k] = int'($signed(f_v[k])); end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; mode = 1'b0; x_in = '0;
    #1;
    for (int k = 0; k < NI; k++) begin
      vec_cnt++; if (f_v[k] !== 24'd0) begin miss_cnt++; $display("FAIL reset_f_out[%0d]: got %0d want 0", k, f_v[k]); end
    end
    vec_cnt++; if (ack_v[0] !== 1'b0) begin miss_cnt++; $display("FAIL reset_ack: got %b want 0", ack_v[0]); end
    vec_cnt++; if (ready_v[0] !== 1'b0) begin miss_cnt++; $display("FAIL reset_ready: got %b want 0", ready_v[0]); end
    vec_cnt++; if (busy_v[0] !== 1'b0) begin miss_cnt++; $display("FAIL reset_busy: got %b want 0", busy_v[0]); end
    repeat (10) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_batch();
    do_reset();
    q_exp.push_back(model(135, 0));
    feed(100, 36, 1'b0);
    vec_cnt++; if (acks !== 36) begin miss_cnt++; $display("FAIL batch_acks: got %0d want 36", acks); end
    wait_results(50);
    vec_cnt++; if (lat[0] !== 10) begin miss_cnt++; $display("FAIL batch_latency: got %0d want 10", lat[0]); end
    vec_cnt++; if (rdy_n[0] !== 1) begin miss_cnt++; $display("FAIL batch_ready_count: got %0d want 1", rdy_n[0]); end
    vec_cnt++; if (busy_n !== 10) begin miss_cnt++; $display("FAIL batch_busy_cycles: got %0d want 10", busy_n); end
    exp_v = q_exp.pop_front();
    vec_cnt++; if (fval[0] !== exp_v) begin miss_cnt++; $display("FAIL batch_f_out: got %0d want %0d", fval[0], exp_v); end
    vec_cnt++; if (fval[1] !== model(135, 8388000)) begin miss_cnt++; $display("FAIL saturate_f_out: got %0d want %0d", fval[1], model(135, 8388000)); end
    vec_cnt++; if (fval[2] !== model(135, -5000)) begin miss_cnt++; $display("FAIL bias_neg_f_out: got %0d want %0d", fval[2], model(135, -5000)); end
    for (int k = 1; k < NI; k++) begin
      vec_cnt++; if (lat[k] !== exp_latency(LANES_V[k])) begin miss_cnt++; $display("FAIL latency[%0d]: got %0d want %0d", k, lat[k], exp_latency(LANES_V[k])); end
    end
    for (int k = 3; k < NI; k++) begin
      vec_cnt++; if (fval[k] !== model(135, 0)) begin miss_cnt++; $display("FAIL lanes_f_out[%0d]: got %0d want %0d", k, fval[k], model(135, 0)); end
    end
    // Batch mode restarts the window: one further sample must not produce a result.
    feed(136, 1, 1'b0);
    wait_results(15);
    vec_cnt++; if (rdy_n[0] !== 0) begin miss_cnt++; $display("FAIL batch_no_overlap: got %0d readies want 0", rdy_n[0]); end
  endtask

  task automatic test_sliding();
    do_reset();
    q_exp.push_back(model(135, 0));
    q_exp.push_back(model(136, 0));
    q_exp.push_back(model(137, 0));
    feed(100, 36, 1'b1);
    wait_results(15);
    exp_v = q_exp.pop_front();
    vec_cnt++; if (fval[0] !== exp_v) begin miss_cnt++; $display("FAIL slide_first_f_out: got %0d want %0d", fval[0], exp_v); end
    for (int s = 136; s <= 137; s++) begin
      feed(s, 1, 1'b1);
      vec_cnt++; if (acks !== 1) begin miss_cnt++; $display("FAIL slide_ack_%0d: got %0d want 1", s, acks); end
      wait_results(15);
      vec_cnt++; if (lat[0] !== 10) begin miss_cnt++; $display("FAIL slide_latency_%0d: got %0d want 10", s, lat[0]); end
      exp_v = q_exp.pop_front();
      vec_cnt++; if (fval[0] !== exp_v) begin miss_cnt++; $display("FAIL slide_f_out_%0d: got %0d want %0d", s, fval[0], exp_v); end
    end
  endtask

  task automatic test_drop();
    logic acked [82];
    int drop_acks, tot_acks, first_seen;
    do_reset();
    q_exp.push_back(model(235, 0));
    q_exp.push_back(model(281, 0));
    first_seen = 0;
    for (int i = 0; i < 82; i++) begin
      @(negedge clk);
      if (i > 0) acked[i-1] = ack_v[0];
      if (ready_v[0]) begin
        first_seen++;
        exp_v = q_exp.pop_front();
        vec_cnt++; if (int'($signed(f_v[0])) !== exp_v) begin miss_cnt++; $display("FAIL drop_first_f_out: got %0d want %0d", $signed(f_v[0]), exp_v); end
      end
      x_in = 12'(200 + i); start = 1'b1; mode = 1'b0;
    end
    @(negedge clk);
    acked[81] = ack_v[0];
    start = 1'b0;
    drop_acks = 0; tot_acks = 0;
    for (int i = 0; i < 82; i++) begin
      if (acked[i]) tot_acks++;
      if (acked[i] && i >= 36 && i <= 45) drop_acks++;
    end
    vec_cnt++; if (first_seen !== 1) begin miss_cnt++; $display("FAIL drop_first_ready: got %0d want 1", first_seen); end
    vec_cnt++; if (drop_acks !== 0) begin miss_cnt++; $display("FAIL drop_busy_acks: got %0d want 0", drop_acks); end
    vec_cnt++; if (tot_acks !== 72) begin miss_cnt++; $display("FAIL drop_total_acks: got %0d want 72", tot_acks); end
    wait_results(15);
    vec_cnt++; if (lat[0] !== 10) begin miss_cnt++; $display("FAIL drop_second_latency: got %0d want 10", lat[0]); end
    if (q_exp.size() > 0) exp_v = q_exp.pop_front(); else exp_v = -1;
    vec_cnt++; if (fval[0] !== exp_v) begin miss_cnt++; $display("FAIL drop_second_f_out: got %0d want %0d", fval[0], exp_v); end
    q_exp.delete();
  endtask

  task automatic test_reset_midfill();
    do_reset();
    feed(100, 36, 1'b0);
    wait_results(15);
    feed(500, 20, 1'b0);
    reset = 1'b0;
    #1;
    vec_cnt++; if (f_v[0] !== 24'd0) begin miss_cnt++; $display("FAIL midfill_f_out: got %0d want 0", f_v[0]); end
    vec_cnt++; if (ack_v[0] !== 1'b0) begin miss_cnt++; $display("FAIL midfill_ack: got %b want 0", ack_v[0]); end
    vec_cnt++; if (busy_v[0] !== 1'b0) begin miss_cnt++; $display("FAIL midfill_busy: got %b want 0", busy_v[0]); end
    vec_cnt++; if (ready_v[0] !== 1'b0) begin miss_cnt++; $display("FAIL midfill_ready: got %b want 0", ready_v[0]); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    q_exp.push_back(model(335, 0));
    feed(300, 36, 1'b0);
    vec_cnt++; if (acks !== 36) begin miss_cnt++; $display("FAIL midfill_acks: got %0d want 36", acks); end
    wait_results(45);
    vec_cnt++; if (rdy_n[0] !== 1) begin miss_cnt++; $display("FAIL midfill_ready_count: got %0d want 1", rdy_n[0]); end
    exp_v = q_exp.pop_front();
    vec_cnt++; if (fval[0] !== exp_v) begin miss_cnt++; $display("FAIL midfill_f_out: got %0d want %0d", fval[0], exp_v); end
  endtask

  initial begin
    test_reset();
    test_batch();
    test_sliding();
    test_drop();
    test_reset_midfill();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
